// File: rtl/regfile_arb_pkg.sv
// Shared widths, the write-back entry type and a register-mask helper for the
// register-file write-port arbiter.
package regfile_arb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry;

    // One-hot mask for a register; r0 never tracks state, so it maps to zero.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (addr != REG_ZERO) begin
            mask[addr] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// In-order buffer for long-unit write-back results. FIFO_DEPTH must be a
// power of two (>= 2) so the pointers wrap naturally.
module wb_skid_fifo
    import regfile_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  wb_entry wdata,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wb_entry head
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    wb_entry         mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    assign full  = (count_q == CntW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read once the count covers it.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between writeback and the long unit and
// tracks outstanding long-unit destinations. REGFILE_ARB_BYPASS_EN adds a 0-cycle path.
module regfile_wb_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0]     pipe_data,
    input  logic                  lu_valid,
    input  logic [REG_ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0]     lu_data,
    output logic                  lu_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_dst,
    input  logic [REG_ADDR_W-1:0] dec_rs,
    input  logic [REG_ADDR_W-1:0] dec_rt,
    output logic                  hazard_stall,
    output logic                  pipe_bubble_req,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0]     rf_data,
    output logic [NUM_REGS-1:0]   pending_mask
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    logic                pipe_act;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                head_grant, bypass;
    wb_entry             head, lu_entry;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic                bubble_q, bubble_d;
    logic [NUM_REGS-1:0] pending_q, pending_d, set_mask, clr_mask;

    // A pipeline write to r0 is treated as an idle slot.
    assign pipe_act = pipe_we && (pipe_addr != REG_ZERO);
    assign lu_ready = !fifo_full && !reset;
    assign lu_entry = '{addr: lu_addr, data: lu_data};

`ifdef REGFILE_ARB_BYPASS_EN
    assign bypass = fifo_empty && !pipe_act && lu_valid && !reset;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push  = lu_valid && lu_ready && !bypass;
    assign head_grant = !fifo_empty && !pipe_act && !reset;
    assign fifo_pop   = head_grant;

    wb_skid_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (lu_entry),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_addr  = '0;
        rf_data  = '0;
        clr_mask = '0;
        if (pipe_act && !reset) begin
            rf_we   = 1'b1;
            rf_addr = pipe_addr;
            rf_data = pipe_data;
        end else if (head_grant) begin
            // An r0 result is still popped, just never written.
            rf_we    = (head.addr != REG_ZERO);
            rf_addr  = head.addr;
            rf_data  = head.data;
            clr_mask = reg_mask(head.addr);
        end else if (bypass) begin
            rf_we    = (lu_addr != REG_ZERO);
            rf_addr  = lu_addr;
            rf_data  = lu_data;
            clr_mask = reg_mask(lu_addr);
        end
    end

    // Stall decision uses the pre-edge mask, so a same-cycle clear still stalls once.
    assign hazard_stall = !reset && (pending_q[dec_rs] || pending_q[dec_rt] ||
                                     (issue_valid && pending_q[issue_dst]));

    always_comb begin
        set_mask  = (issue_valid && !hazard_stall) ? reg_mask(issue_dst) : '0;
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_comb begin
        wait_d = wait_q;
        if (fifo_empty || head_grant) begin
            wait_d = '0;
        end else if (wait_q != WaitW'(MAX_WAIT)) begin
            wait_d = wait_q + WaitW'(1);
        end
        bubble_d = (wait_d == WaitW'(MAX_WAIT));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= '0;
            wait_q    <= '0;
            bubble_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            wait_q    <= wait_d;
            bubble_q  <= bubble_d;
        end
    end

    assign pipe_bubble_req = bubble_q;
    assign pending_mask    = pending_q;

    bubble_honoured: assert property (@(posedge clock) disable iff (reset)
        pipe_bubble_req |-> !pipe_act);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected register-file writes are queued
// with their cycle and checked by an independent write monitor.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_addr = '0;
    logic [31:0] pipe_data = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_addr = '0;
    logic [31:0] lu_data = '0;
    logic        lu_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_dst = '0;
    logic [4:0]  dec_rs = '0;
    logic [4:0]  dec_rt = '0;
    logic        hazard_stall;
    logic        pipe_bubble_req;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] pending_mask;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    regfile_wb_arbiter #(
        .FIFO_DEPTH (2),
        .MAX_WAIT   (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pipe_we         (pipe_we),
        .pipe_addr       (pipe_addr),
        .pipe_data       (pipe_data),
        .lu_valid        (lu_valid),
        .lu_addr         (lu_addr),
        .lu_data         (lu_data),
        .lu_ready        (lu_ready),
        .issue_valid     (issue_valid),
        .issue_dst       (issue_dst),
        .dec_rs          (dec_rs),
        .dec_rt          (dec_rt),
        .hazard_stall    (hazard_stall),
        .pipe_bubble_req (pipe_bubble_req),
        .rf_we           (rf_we),
        .rf_addr         (rf_addr),
        .rf_data         (rf_data),
        .pending_mask    (pending_mask)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic samp();
        @(negedge clock);
    endtask

    task automatic expect_wr(input int at, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.cyc  = at;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pipe_wr(input logic [4:0] a, input logic [31:0] d);
        pipe_we   = 1'b1;
        pipe_addr = a;
        pipe_data = d;
        expect_wr(cyc, a, d);
    endtask

    task automatic pipe_idle();
        pipe_we   = 1'b0;
        pipe_addr = '0;
        pipe_data = '0;
    endtask

    task automatic lu_drive(input logic v, input logic [4:0] a, input logic [31:0] d);
        lu_valid = v;
        lu_addr  = a;
        lu_data  = d;
    endtask

    // Write monitor: every rf_we must match the next queued write, cycle included.
    always @(negedge clock) begin
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=r%0d/%h required=none (cycle %0d)",
                         rf_addr, rf_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(rf_addr), 32'(e.addr));
                check("wr_data", rf_data, e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        next();
        next();
        samp();
        check("rst_lu_ready", 32'(lu_ready), 0);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_hazard", 32'(hazard_stall), 0);
        check("rst_bubble", 32'(pipe_bubble_req), 0);
        check("rst_pending", pending_mask, 0);
        check("rst_rf_addr", 32'(rf_addr), 0);
        check("rst_rf_data", rf_data, 0);
        next();
        reset = 1'b0;
        samp();
        check("post_rst_lu_ready", 32'(lu_ready), 1);

        // Pipeline write, zero latency
        next();
        pipe_wr(5'd5, 32'h0000_1234);
        samp();
        check("pipe_pending", pending_mask, 0);
        next();
        pipe_idle();

        // Issue r8, long-unit result one cycle later, RAW stall on rs=8
        issue_valid = 1'b1;
        issue_dst   = 5'd8;
        samp();
        check("issue_no_stall", 32'(hazard_stall), 0);
        next();
        issue_valid = 1'b0;
        issue_dst   = '0;
        lu_drive(1'b1, 5'd8, 32'hDEAD_BEEF);
        dec_rs = 5'd8;
        expect_wr(cyc + 1, 5'd8, 32'hDEAD_BEEF);
        samp();
        check("r8_pending", pending_mask, 32'h0000_0100);
        check("r8_stall_0", 32'(hazard_stall), 1);
        check("r8_lu_ready", 32'(lu_ready), 1);
        next();
        lu_drive(1'b0, '0, '0);
        samp();
        check("r8_stall_1", 32'(hazard_stall), 1);
        check("r8_pending_wr", pending_mask, 32'h0000_0100);
        next();
        samp();
        check("r8_cleared", pending_mask, 0);
        check("r8_no_stall", 32'(hazard_stall), 0);
        dec_rs = '0;

        // Starvation: pipe busy while r9 waits, bubble after 4 losses
        next();
        lu_drive(1'b1, 5'd9, 32'h0000_0099);
        pipe_wr(5'd1, 32'h0000_0100);
        samp();
        check("starve_bubble_a", 32'(pipe_bubble_req), 0);
        for (int i = 0; i < 4; i++) begin
            next();
            lu_drive(1'b0, '0, '0);
            pipe_wr(5'd1, 32'h0000_0101 + 32'(i));
            samp();
            check("starve_bubble_lose", 32'(pipe_bubble_req), 0);
        end
        next();
        pipe_idle();
        expect_wr(cyc, 5'd9, 32'h0000_0099);
        samp();
        check("starve_bubble_on", 32'(pipe_bubble_req), 1);
        next();
        samp();
        check("starve_bubble_off", 32'(pipe_bubble_req), 0);

        // Full FIFO: three back-to-back results with the pipe busy
        next();
        lu_drive(1'b1, 5'd10, 32'hA000_000A);
        pipe_wr(5'd2, 32'h0000_0200);
        samp();
        check("full_ready_0", 32'(lu_ready), 1);
        next();
        lu_drive(1'b1, 5'd11, 32'hB000_000B);
        pipe_wr(5'd2, 32'h0000_0201);
        samp();
        check("full_ready_1", 32'(lu_ready), 1);
        next();
        lu_drive(1'b1, 5'd12, 32'hC000_000C);
        pipe_wr(5'd2, 32'h0000_0202);
        samp();
        check("full_ready_2", 32'(lu_ready), 0);
        next();
        pipe_wr(5'd2, 32'h0000_0203);
        samp();
        check("full_ready_3", 32'(lu_ready), 0);
        next();
        pipe_idle();
        expect_wr(cyc, 5'd10, 32'hA000_000A);
        samp();
        check("full_ready_pop", 32'(lu_ready), 0);
        next();
        expect_wr(cyc, 5'd11, 32'hB000_000B);
        samp();
        check("pushpop_ready", 32'(lu_ready), 1);
        next();
        lu_drive(1'b0, '0, '0);
        expect_wr(cyc, 5'd12, 32'hC000_000C);
        samp();
        check("pushpop_count", 32'(lu_ready), 1);
        next();
        samp();
        check("drained_pending", pending_mask, 0);

        // Reset with two buffered entries and pending bits set
        next();
        issue_valid = 1'b1;
        issue_dst   = 5'd13;
        pipe_wr(5'd3, 32'h0000_0300);
        samp();
        check("r13_issue_stall", 32'(hazard_stall), 0);
        next();
        issue_dst = 5'd14;
        lu_drive(1'b1, 5'd13, 32'h0000_D013);
        pipe_wr(5'd3, 32'h0000_0301);
        samp();
        check("r14_issue_stall", 32'(hazard_stall), 0);
        next();
        issue_valid = 1'b0;
        issue_dst   = '0;
        lu_drive(1'b1, 5'd14, 32'h0000_D014);
        pipe_wr(5'd3, 32'h0000_0302);
        samp();
        check("r13_r14_pending", pending_mask, 32'h0000_6000);
        next();
        lu_drive(1'b0, '0, '0);
        pipe_wr(5'd3, 32'h0000_0303);
        dec_rt = 5'd13;
        samp();
        check("rt13_stall", 32'(hazard_stall), 1);
        check("rst_full_ready", 32'(lu_ready), 0);
        next();
        pipe_idle();
        reset = 1'b1;
        samp();
        check("midrst_rf_we", 32'(rf_we), 0);
        check("midrst_ready", 32'(lu_ready), 0);
        check("midrst_stall", 32'(hazard_stall), 0);
        next();
        reset = 1'b0;
        samp();
        check("postrst_pending", pending_mask, 0);
        check("postrst_rf_we", 32'(rf_we), 0);
        check("postrst_ready", 32'(lu_ready), 1);
        check("postrst_stall", 32'(hazard_stall), 0);
        dec_rt = '0;
        for (int i = 0; i < 3; i++) begin
            next();
            samp();
            check("postrst_idle", 32'(rf_we), 0);
        end

        check("writes_outstanding", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - the in-order pipeline writeback stage (cannot stall);
  - the long-latency unit (mult/div) through a valid/ready handshake.
- Keeps a 32-bit scoreboard of registers with an outstanding long-unit write, and stalls decode on RAW/WAW hazards against them.
- Sits between writeback/long-unit outputs and the register file write inputs (we, addr, data).

Parameters:
- FIFO_DEPTH, 2: long-unit result buffer entries (power of two, >=2).
- MAX_WAIT, 4: cycles a buffered long-unit result may lose arbitration before a pipeline bubble is requested.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- pipe_we  in  1  pipeline writeback request
- pipe_addr  in  5  pipeline destination register
- pipe_data  in  32  pipeline writeback data
- lu_valid  in  1  long-unit result valid
- lu_addr  in  5  long-unit destination register
- lu_data  in  32  long-unit result data
- lu_ready  out  1  buffer can accept a result
- issue_valid  in  1  decode issues a long-unit op this cycle
- issue_dst  in  5  destination of the issued op
- dec_rs  in  5  decode source register rs
- dec_rt  in  5  decode source register rt
- hazard_stall  out  1  decode must hold
- pipe_bubble_req  out  1  pipeline must drop its writeback next cycle
- rf_we  out  1  register file write enable
- rf_addr  out  5  register file write address
- rf_data  out  32  register file write data
- pending_mask  out  32  bit i set = register i has an outstanding long-unit write

Behaviour:
- Reset values:
  - FIFO empty, pending_mask=0, wait counter=0.
  - lu_ready=0 while reset is high.
  - pipe_bubble_req=0, rf_we=0, hazard_stall=0.
  - rf_addr/rf_data=0.
  - Reset mid-operation discards all buffered results and pending bits.
- Long-unit handshake:
  - Transfer occurs when lu_valid && lu_ready at a rising edge.
  - lu_ready = !full && !reset.
  - lu_valid must stay asserted with stable addr/data until the transfer.
- Arbitration (combinational, same cycle):
  - pipe_we=1 and pipe_addr!=0: pipeline is granted; rf_* = pipe_*.
  - Otherwise, if FIFO is non-empty: the head is granted and popped at the edge.
  - Otherwise: rf_we=0.
  - Writes to register 0 are never issued: a pipe write to r0 counts as idle; a long-unit result to r0 is buffered and popped with rf_we=0.
- Latency:
  - Pipeline path: 0 cycles.
  - Long-unit path: at least 1 cycle (enter FIFO, then write).
  - FIFO is strictly in order.
- Starvation:
  - The wait counter increments each cycle the head is present and not granted; it clears when the head is granted.
  - Counter saturated at MAX_WAIT asserts pipe_bubble_req (registered).
  - The pipeline guarantees pipe_we=0 in the following cycle, which grants the head.
  - If pipe_we is still 1, the pipeline keeps priority and the request stays asserted (assertion flags this).
- Scoreboard:
  - issue_valid && !hazard_stall sets pending[issue_dst] (r0 is never set).
  - A head write to register k clears pending[k].
  - Simultaneous set and clear of the same bit: set wins.
  - hazard_stall = pending[dec_rs] | pending[dec_rt] | (issue_valid & pending[issue_dst]).
  - The test uses the pre-edge mask, so a clear in the same cycle still stalls once.
- Full FIFO: lu_ready=0; a push and a pop in the same cycle are legal when not full, and count is unchanged.

Optional Feature:
- Macro: REGFILE_ARB_BYPASS_EN.
- Defined: when the FIFO is empty, the pipeline is idle and lu_valid=1, the long-unit result is written to rf_* in the same cycle without entering the FIFO (0-cycle latency). The pending bit clears at that edge.
- Undefined: all long-unit results pass through the FIFO.

Decomposition:
- Shared package/header regfile_arb_pkg holds:
  - REG_ADDR_W=5, DATA_W=32, REG_ZERO=0;
  - the wb_entry typedef {addr, data}.
- Sub-module wb_skid_fifo holds storage and pointers:
  - parameter FIFO_DEPTH;
  - push/pop/full/empty/head.
- Arbitration, wait counter and scoreboard live in the top.

Test Plan:
- Pipe write r5=0x1234 with no long-unit activity -> rf_we=1, rf_addr=5, rf_data=0x1234 in the same cycle; pending_mask=0.
- Issue dst r8, then lu result r8=0xDEADBEEF with the pipe idle -> pending[8]=1 until the write; rf write one cycle after the transfer (bypass off); pending[8]=0 afterwards.
- Decode dec_rs=8 while pending[8]=1 -> hazard_stall=1 each cycle until the clearing edge, then 0.
- Pipe writes every cycle while a long-unit result waits, MAX_WAIT=4 -> pipe_bubble_req rises after 4 losses; head written on the bubble cycle; counter returns to 0.
- Three lu results back-to-back with the pipe busy, FIFO_DEPTH=2 -> lu_ready=0 after two transfers; third held stable until space; writes occur in order.
- Reset asserted with two buffered entries and pending bits set -> next cycle FIFO empty, pending_mask=0, no rf_we for the discarded entries.
